// File: rtl/mips_bus_mem_unit_if.sv
// Avalon-MM master port bundle between the memory unit and the system bus.
// Latency: none, pure wiring.
// Backpressure: slave stalls the master by holding waitrequest high.
interface mips_bus_mem_unit_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata
    );
endinterface

// File: rtl/mips_bus_mem_unit.sv
// Memory unit: arbitrates fetch vs data onto one Avalon bus, steers lanes, extends/merges loads.
// Latency: req seen in IDLE at N, strobe at N+1, done at N+2 with zero wait states.
// Backpressure: strobes held while waitrequest=1; aborts with err after WAIT_LIMIT stalled cycles.
module mips_bus_mem_unit #(
    parameter int WAIT_LIMIT = 16,
    parameter int CNT_W      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    output logic        fetch_done,
    output logic [31:0] fetch_instr,
    output logic        fetch_err,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [1:0]  mem_size,
    input  logic        mem_signed,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [31:0] mem_rt_old,
    output logic        mem_done,
    output logic [31:0] mem_rdata,
    output logic        mem_err,
    output logic        busy,
    mips_bus_mem_unit_if.master bus
);
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(WAIT_LIMIT - 1);

    state_t state_q, state_d;

    // Operands of the accepted request
    logic             own_mem_q, we_q, sgn_q;
    logic [1:0]       size_q, off_q;
    logic [31:0]      rt_q;
    logic [CNT_W-1:0] wait_cnt_q;

    // Registered outputs and their next values
    logic [31:0] address_q, address_d, wd_q, wd_d;
    logic [3:0]  be_q, be_d;
    logic        read_q, read_d, write_q, write_d;
    logic        fetch_done_q, fetch_done_d, fetch_err_q, fetch_err_d;
    logic        mem_done_q, mem_done_d, mem_err_q, mem_err_d;
    logic [31:0] fetch_instr_q, fetch_instr_d, mem_rdata_q, mem_rdata_d;

    // Accept-side decode
    logic        take_any, acc_bad, acc_we;
    logic [31:0] acc_addr, acc_wd;
    logic [3:0]  acc_be;
    logic        timeout;

    // Load extension and LWL/LWR merge; b is the byte offset within the word
    function automatic logic [31:0] load_result(input logic [31:0] rd, input logic [1:0] size,
                                                input logic sgn, input logic [1:0] b,
                                                input logic [31:0] rt);
        logic [4:0]  sh_b, sh_l;
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [31:0] res;
        sh_b   = {b, 3'b000};
        sh_l   = {~b, 3'b000};
        byte_v = 8'(rd >> sh_b);
        half_v = b[1] ? rd[31:16] : rd[15:0];
        case (size)
            2'd0:    res = {{24{sgn & byte_v[7]}}, byte_v};
            2'd1:    res = {{16{sgn & half_v[15]}}, half_v};
            2'd2:    res = rd;
            default: res = sgn ? ((rd >> sh_b) | (rt & ~(32'hFFFF_FFFF >> sh_b)))
                               : ((rd << sh_l) | (rt & ~(32'hFFFF_FFFF << sh_l)));
        endcase
        return res;
    endfunction

    assign timeout = (WAIT_LIMIT != 0) && (wait_cnt_q == LIMIT_M1);

    // Decode the request that IDLE would accept this cycle (data wins)
    always_comb begin
        take_any = mem_req | fetch_req;
        acc_addr = mem_req ? mem_addr : fetch_addr;
        acc_we   = mem_req & mem_we;
        acc_bad  = 1'b0;
        acc_be   = 4'b1111;
        acc_wd   = 32'h0;
        if (mem_req) begin
            case (mem_size)
                2'd1:    acc_bad = mem_addr[0];
                2'd2:    acc_bad = (mem_addr[1:0] != 2'b00);
                2'd3:    acc_bad = mem_we;
                default: acc_bad = 1'b0;
            endcase
            if (mem_we) begin
                case (mem_size)
                    2'd0: begin
                        acc_be = 4'b0001 << mem_addr[1:0];
                        acc_wd = {4{mem_wdata[7:0]}};
                    end
                    2'd1: begin
                        acc_be = mem_addr[1] ? 4'b1100 : 4'b0011;
                        acc_wd = {2{mem_wdata[15:0]}};
                    end
                    default: begin
                        acc_be = 4'b1111;
                        acc_wd = mem_wdata;
                    end
                endcase
            end
        end else begin
            acc_bad = (fetch_addr[1:0] != 2'b00);
        end
    end

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            address_q     <= 32'h0;
            wd_q          <= 32'h0;
            be_q          <= 4'b0000;
            read_q        <= 1'b0;
            write_q       <= 1'b0;
            fetch_done_q  <= 1'b0;
            fetch_err_q   <= 1'b0;
            fetch_instr_q <= 32'h0;
            mem_done_q    <= 1'b0;
            mem_err_q     <= 1'b0;
            mem_rdata_q   <= 32'h0;
        end else begin
            state_q       <= state_d;
            address_q     <= address_d;
            wd_q          <= wd_d;
            be_q          <= be_d;
            read_q        <= read_d;
            write_q       <= write_d;
            fetch_done_q  <= fetch_done_d;
            fetch_err_q   <= fetch_err_d;
            fetch_instr_q <= fetch_instr_d;
            mem_done_q    <= mem_done_d;
            mem_err_q     <= mem_err_d;
            mem_rdata_q   <= mem_rdata_d;
        end
    end

    // Next-state: bad requests skip the bus, bus ends on ready or timeout, RESP lasts one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (take_any) state_d = acc_bad ? RESP : BUS;
            BUS:     if (!bus.waitrequest || timeout) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next output values; done/err are single-cycle, bus fields hold while stalled
    always_comb begin
        address_d     = address_q;
        wd_d          = wd_q;
        be_d          = be_q;
        read_d        = read_q;
        write_d       = write_q;
        fetch_instr_d = fetch_instr_q;
        mem_rdata_d   = mem_rdata_q;
        fetch_done_d  = 1'b0;
        fetch_err_d   = 1'b0;
        mem_done_d    = 1'b0;
        mem_err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (take_any && acc_bad) begin
                    mem_done_d   = mem_req;
                    mem_err_d    = mem_req;
                    fetch_done_d = !mem_req;
                    fetch_err_d  = !mem_req;
                    if (mem_req) mem_rdata_d = 32'h0;
                end else if (take_any) begin
                    address_d = {acc_addr[31:2], 2'b00};
                    read_d    = !acc_we;
                    write_d   = acc_we;
                    be_d      = acc_be;
                    wd_d      = acc_wd;
                end
            end
            BUS: begin
                if (!bus.waitrequest || timeout) begin
                    read_d       = 1'b0;
                    write_d      = 1'b0;
                    mem_done_d   = own_mem_q;
                    fetch_done_d = !own_mem_q;
                    mem_err_d    = own_mem_q & bus.waitrequest;
                    fetch_err_d  = !own_mem_q & bus.waitrequest;
                    if (own_mem_q)
                        mem_rdata_d = (we_q || bus.waitrequest) ? 32'h0
                                    : load_result(bus.readdata, size_q, sgn_q, off_q, rt_q);
                    else if (!bus.waitrequest)
                        fetch_instr_d = bus.readdata;
                end
            end
            default: ;
        endcase
    end

    // Latch accepted operands and count stalled bus cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            own_mem_q  <= 1'b0;
            we_q       <= 1'b0;
            sgn_q      <= 1'b0;
            size_q     <= 2'd0;
            off_q      <= 2'd0;
            rt_q       <= 32'h0;
            wait_cnt_q <= '0;
        end else if (state_q == IDLE) begin
            wait_cnt_q <= '0;
            if (take_any) begin
                own_mem_q <= mem_req;
                we_q      <= acc_we;
                sgn_q     <= mem_signed;
                size_q    <= mem_req ? mem_size : 2'd2;
                off_q     <= acc_addr[1:0];
                rt_q      <= mem_rt_old;
            end
        end else if (state_q == BUS && bus.waitrequest) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
        end
    end

    assign busy           = (state_q != IDLE);
    assign fetch_done     = fetch_done_q;
    assign fetch_err      = fetch_err_q;
    assign fetch_instr    = fetch_instr_q;
    assign mem_done       = mem_done_q;
    assign mem_err        = mem_err_q;
    assign mem_rdata      = mem_rdata_q;
    assign bus.address    = address_q;
    assign bus.read       = read_q;
    assign bus.write      = write_q;
    assign bus.writedata  = wd_q;
    assign bus.byteenable = be_q;
endmodule
